// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - label-checked single-outstanding memory access sequencer
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_we, req_base, req_count, req_lbtype, req_type, req_ofs, req_wdata
//                               access direction, label fields, pointer offset, write data
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata
//                               synchronous RAM port, read data RD_LAT cycles after the sampling edge
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_fault        read data (0 for writes/faults), fault code 0 ok / 1 bounds / 2 type
module mem_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [15:0]       req_base,
    input  logic [15:0]       req_count,
    input  logic [7:0]        req_lbtype,
    input  logic [7:0]        req_type,
    input  logic [15:0]       req_ofs,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [15:0]       ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_OK     = 2'd0;
    localparam logic [1:0] FAULT_BOUNDS = 2'd1;
    localparam logic [1:0] FAULT_TYPE   = 2'd2;
    localparam logic [1:0] LAT_INIT     = 2'(RD_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  lat_cnt;
    logic [1:0]  fault_q;
    logic        we_q;

    logic        accept;
    logic [16:0] sum17;
    logic [1:0]  fault_in;

    // The legality check is evaluated on the request as it is captured so the
    // RAM strobe can be registered and still land in the ISSUE cycle; the
    // result is held in fault_q/we_q for the ISSUE decision.
    always_comb begin
        accept = req_valid && req_ready;
        sum17  = {1'b0, req_base} + {1'b0, req_ofs};
        if (req_lbtype != req_type)
            fault_in = FAULT_TYPE;
        else if ((req_ofs >= req_count) || sum17[16])
            fault_in = FAULT_BOUNDS;
        else
            fault_in = FAULT_OK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: state_nxt = ((fault_q != FAULT_OK) || we_q) ? RESP : WAIT;
            WAIT:  if (lat_cnt == 2'd0) state_nxt = RESP;
            RESP:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= FAULT_OK;
            lat_cnt   <= 2'd0;
            fault_q   <= FAULT_OK;
            we_q      <= 1'b0;
        end else begin
            // RAM strobe is a single-cycle pulse; address/data return to 0 with it.
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        fault_q   <= fault_in;
                        we_q      <= req_we;
                        if (fault_in == FAULT_OK) begin
                            ram_en    <= 1'b1;
                            ram_we    <= req_we;
                            ram_addr  <= sum17[15:0];
                            ram_wdata <= req_we ? req_wdata : '0;
                        end
                    end
                end
                ISSUE: begin
                    rsp_fault <= fault_q;
                    rsp_rdata <= '0;
                    if ((fault_q == FAULT_OK) && !we_q)
                        lat_cnt <= LAT_INIT;
                    else
                        rsp_valid <= 1'b1;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        rsp_rdata <= ram_rdata;
                        rsp_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
